// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of the single data_memory port.
// One access is accepted per cycle. The response (done/err/rdata) follows the grant by one cycle.
module dmem_arbiter #(
   parameter int unsigned FIXED_PRIO   = 0,
   parameter int unsigned STARVE_LIMIT = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        a_req_in,
   input  logic        a_we_in,
   input  logic [31:0] a_addr_in,
   input  logic [31:0] a_wdata_in,
   input  logic [1:0]  a_size_in,
   output logic        a_gnt_out,
   output logic        a_done_out,
   output logic        a_err_out,
   output logic [31:0] a_rdata_out,
   input  logic        b_req_in,
   input  logic        b_we_in,
   input  logic [31:0] b_addr_in,
   input  logic [31:0] b_wdata_in,
   input  logic [1:0]  b_size_in,
   output logic        b_gnt_out,
   output logic        b_done_out,
   output logic        b_err_out,
   output logic [31:0] b_rdata_out,
   output logic [31:0] mem_addr_out,
   output logic [31:0] mem_writedata_out,
   output logic [1:0]  mem_size_out,
   output logic        mem_re_out,
   output logic        mem_we_out,
   input  logic [31:0] mem_readdata_in
);

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = 2;
   localparam int unsigned CW = 8;

   typedef enum logic {IDLE, ACCESS} state_t;
   typedef enum logic [1:0] {RESP_NONE, RESP_A, RESP_B} resp_t;

   state_t        state, state_nxt;
   resp_t         resp_nxt;
   logic          last_b, last_b_nxt;
   logic [CW-1:0] starve_cnt, starve_nxt;
   logic          acc_err;
   logic          a_elig, b_elig, a_win, b_win, any_win;
   logic [AW-1:0] win_addr;
   logic [DW-1:0] win_wdata;
   logic [SW-1:0] win_size;
   logic          win_we, win_mapped;

   // Data, stack and serial MMIO segments.
   function automatic logic is_mapped(input logic [AW-1:0] addr);
      return (addr[31:16] == 16'h1000) || (addr[31:16] == 16'h7fff) ||
             (addr[31:16] == 16'hffff);
   endfunction

   // Arbitration, starvation counter and response-stage decode.
   always_comb begin
      state_nxt  = IDLE;
      resp_nxt   = RESP_NONE;
      last_b_nxt = last_b;
      starve_nxt = starve_cnt;
      a_win      = 1'b0;
      b_win      = 1'b0;
      // A request still showing its own grant was already taken.
      a_elig     = a_req_in & ~a_gnt_out;
      b_elig     = b_req_in & ~b_gnt_out;
      if (a_elig && b_elig) begin
         if (FIXED_PRIO != 0)
            b_win = (32'(starve_cnt) >= STARVE_LIMIT);
         else
            b_win = ~last_b;
         a_win = ~b_win;
      end else begin
         a_win = a_elig;
         b_win = b_elig;
      end
      any_win = a_win | b_win;
      if (any_win) begin
         state_nxt  = ACCESS;
         last_b_nxt = b_win;
      end
      if (!b_req_in || b_win)
         starve_nxt = '0;
      else if (b_elig && (starve_cnt != {CW{1'b1}}))
         starve_nxt = starve_cnt + CW'(1);
      if (state == ACCESS)
         resp_nxt = a_gnt_out ? RESP_A : RESP_B;
      win_addr   = b_win ? b_addr_in  : a_addr_in;
      win_wdata  = b_win ? b_wdata_in : a_wdata_in;
      win_size   = b_win ? b_size_in  : a_size_in;
      win_we     = b_win ? b_we_in    : a_we_in;
      win_mapped = is_mapped(win_addr);
   end

   // State, memory port and response registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state             <= IDLE;
         last_b            <= 1'b1;
         starve_cnt        <= '0;
         acc_err           <= 1'b0;
         a_gnt_out         <= 1'b0;
         b_gnt_out         <= 1'b0;
         a_done_out        <= 1'b0;
         b_done_out        <= 1'b0;
         a_err_out         <= 1'b0;
         b_err_out         <= 1'b0;
         a_rdata_out       <= '0;
         b_rdata_out       <= '0;
         mem_addr_out      <= '0;
         mem_writedata_out <= '0;
         mem_size_out      <= '0;
         mem_re_out        <= 1'b0;
         mem_we_out        <= 1'b0;
      end else begin
         state      <= state_nxt;
         last_b     <= last_b_nxt;
         starve_cnt <= starve_nxt;
         a_gnt_out  <= a_win;
         b_gnt_out  <= b_win;
         mem_re_out <= any_win & win_mapped & ~win_we;
         mem_we_out <= any_win & win_mapped & win_we;
         if (any_win) begin
            mem_addr_out      <= win_addr;
            mem_writedata_out <= win_wdata;
            mem_size_out      <= win_size;
            acc_err           <= ~win_mapped;
         end
         a_done_out <= (resp_nxt == RESP_A);
         b_done_out <= (resp_nxt == RESP_B);
         a_err_out  <= (resp_nxt == RESP_A) & acc_err;
         b_err_out  <= (resp_nxt == RESP_B) & acc_err;
         // The read strobe is only ever set for a mapped read.
         if ((resp_nxt == RESP_A) && mem_re_out)
            a_rdata_out <= mem_readdata_in;
         if ((resp_nxt == RESP_B) && mem_re_out)
            b_rdata_out <= mem_readdata_in;
      end
   end

endmodule
